// File: rtl/exception_sequencer.sv
// exception_sequencer: stateful exception and interrupt sequencer for the LEG core.
// Drives pipeline flush/stall, the one-hot PC vector select and PC save.
module exception_sequencer #(
    parameter  int NUM_IRQ      = 4,
    parameter  int DRAIN_STAGES = 3,
    localparam int SRC_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               UndefinedInstrE,
    input  logic               SWIE,
    input  logic               PrefetchAbortE,
    input  logic               DataAbortM,
    input  logic               FIQ,
    input  logic [NUM_IRQ-1:0] IRQLines,
    input  logic [NUM_IRQ-1:0] IRQMask,
    input  logic               IRQEnabled,
    input  logic               FIQEnabled,
    input  logic               MicroOpBusyD,
    output logic               PipelineClearF,
    output logic               ExceptionFlushD,
    output logic               ExceptionFlushE,
    output logic               ExceptionFlushM,
    output logic               ExceptionFlushW,
    output logic               ExceptionStallD,
    output logic [6:0]         PCVectorAddress,
    output logic               ExceptionSavePC,
    output logic               PCInSelect,
    output logic               IRQAssert,
    output logic               FIQAssert,
    output logic [SRC_W-1:0]   IRQSource,
    output logic               Busy
);

    localparam int CNT_W = $clog2(DRAIN_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ABORT2,
        DRAIN,
        TAKE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_IRQ-1:0] irq_act;
    logic               irq_req, fiq_req, exc_e;
    logic [SRC_W-1:0]   irq_src;

    assign irq_act = IRQLines & IRQMask;
    assign irq_req = IRQEnabled & (|irq_act);
    assign fiq_req = FIQEnabled & FIQ;
    assign exc_e   = PrefetchAbortE | UndefinedInstrE | SWIE;

    // Scan downwards so the lowest active line wins.
    always_comb begin
        irq_src = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) irq_src = SRC_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        PipelineClearF  = 1'b0;
        ExceptionFlushD = 1'b0;
        ExceptionFlushE = 1'b0;
        ExceptionFlushM = 1'b0;
        ExceptionFlushW = 1'b0;
        ExceptionStallD = 1'b0;
        PCVectorAddress = 7'b0;
        PCInSelect      = 1'b0;
        IRQAssert       = 1'b0;
        FIQAssert       = 1'b0;
        IRQSource       = '0;
        if (reset) begin
            PCVectorAddress = 7'b0000001;
            ExceptionFlushD = 1'b1;
            ExceptionFlushE = 1'b1;
            ExceptionFlushM = 1'b1;
            ExceptionFlushW = 1'b1;
            state_n         = IDLE;
            cnt_n           = '0;
        end else if (state == ABORT2) begin
            PCVectorAddress = 7'b0010000;
            PCInSelect      = 1'b1;
            ExceptionFlushD = 1'b1;
            ExceptionFlushE = 1'b1;
            state_n         = IDLE;
        end else if (DataAbortM) begin
            ExceptionFlushD = 1'b1;
            ExceptionFlushE = 1'b1;
            ExceptionFlushM = 1'b1;
            ExceptionFlushW = 1'b1;
            state_n         = ABORT2;
            cnt_n           = '0;
        end else if (exc_e) begin
            if (PrefetchAbortE)       PCVectorAddress = 7'b0001000;
            else if (UndefinedInstrE) PCVectorAddress = 7'b0000010;
            else                      PCVectorAddress = 7'b0000100;
            PCInSelect      = 1'b1;
            ExceptionFlushD = 1'b1;
            ExceptionFlushE = 1'b1;
            ExceptionFlushM = 1'b1;
            state_n         = IDLE;
            cnt_n           = '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((fiq_req | irq_req) & ~MicroOpBusyD) begin
                        PipelineClearF = 1'b1;
                        cnt_n          = CNT_W'(DRAIN_STAGES);
                        state_n        = DRAIN;
                    end
                end
                DRAIN: begin
                    ExceptionStallD = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        cnt_n   = '0;
                        state_n = TAKE;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                TAKE: begin
                    state_n = IDLE;
                    if (fiq_req) begin
                        FIQAssert       = 1'b1;
                        PCVectorAddress = 7'b1000000;
                        ExceptionFlushD = 1'b1;
                        ExceptionFlushE = 1'b1;
                    end else if (irq_req) begin
                        IRQAssert       = 1'b1;
                        IRQSource       = irq_src;
                        PCVectorAddress = 7'b0100000;
                        ExceptionFlushD = 1'b1;
                        ExceptionFlushE = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign ExceptionSavePC = |PCVectorAddress;
    assign Busy            = (state != IDLE) & ~reset;

endmodule
